cache_access_master: RTL
========================

// Module: cache_access_master
// PURPOSE
//  Requester-side controller for the direct-mapped cache: takes CPU commands over a valid/ready channel and drives the cache's address/data_in/read_write port.
//  It samples the cache's registered hit/data_out and services read misses from backing memory, then refills the cache with a one-cycle write.
//  Writes are write-through to memory. Returns one response per command; keeps saturating hit/miss counters.
// PARAMETERS
//  ADDR_W       32   address width (cache port is 32b)
//  DATA_W       32   data width
//  CNT_W        16   width of hit/miss counters
//  MEM_TIMEOUT  255  max cycles waiting mem_ack before error (>=1)
// PORTS
//  clk               in   1       clock, rising edge
//  reset             in   1       asynchronous, active-high
//  cmd_valid         in   1       command present
//  cmd_ready         out  1       controller can accept command
//  cmd_write         in   1       1=write, 0=read
//  cmd_addr          in   ADDR_W  command address
//  cmd_wdata         in   DATA_W  write data
//  rsp_valid         out  1       response present
//  rsp_ready         in   1       response consumed
//  rsp_rdata         out  DATA_W  read data (0 for writes/errors)
//  rsp_hit           out  1       1=cache hit
//  rsp_err           out  1       1=memory timeout
//  cache_address     out  ADDR_W  to cache address
//  cache_data_in     out  DATA_W  to cache data_in
//  cache_read_write  out  1       to cache read_write (1=write)
//  cache_data_out    in   DATA_W  from cache, registered by cache
//  cache_hit         in   1       from cache, registered by cache
//  mem_req           out  1       memory request, held until mem_ack
//  mem_write         out  1       1=memory write
//  mem_addr          out  ADDR_W  memory address
//  mem_wdata         out  DATA_W  memory write data
//  mem_ack           in   1       single-cycle completion
//  mem_rdata         in   DATA_W  valid with mem_ack on reads
//  hit_count         out  CNT_W   saturating hit counter
//  miss_count        out  CNT_W   saturating miss counter
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE; cmd_ready goes 1 in the first cycle after reset deasserts. Reset mid-operation aborts immediately, drops mem_req, and discards the in-flight command.
//  All outputs are registered. cache_read_write is 1 for exactly one cycle per cache write (ISSUE of a write, FILL) and is 0 in every other cycle.
//  The cache acts every cycle. When idle, cache_address holds its last value with read_write=0, which has no side effects.
//  States: IDLE, ISSUE, CHECK, MEM_RD, FILL, MEM_WR, RESP.
//  IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch cmd_* and go to ISSUE.
//  ISSUE (1 cycle): drive cache_address=addr, cache_data_in=wdata, cache_read_write=write. Go to CHECK.
//  CHECK (1 cycle): sample cache_hit/cache_data_out. cache_hit=1 increments hit_count; otherwise increments miss_count.
//    read hit  -> RESP with rdata=cache_data_out, hit=1.
//    read miss -> MEM_RD.
//    write (hit or allocate) -> MEM_WR, with rsp_hit latched from cache_hit.
//  MEM_RD: mem_req=1, mem_write=0, mem_addr=addr. On mem_ack, latch mem_rdata and go to FILL.
//  FILL (1 cycle): cache write of addr with the fetched data. Go to RESP with rdata=fetched, hit=0.
//  MEM_WR: mem_req=1, mem_write=1, mem_wdata=wdata. On mem_ack, go to RESP.
//  mem_req drops in the cycle after mem_ack. A mem_ack seen outside MEM_RD/MEM_WR is ignored.
//  Timeout: a counter clears on entry to MEM_RD/MEM_WR. After MEM_TIMEOUT cycles with no ack: drop mem_req, skip FILL, go to RESP with rsp_err=1, rdata=0.
//  RESP: rsp_valid=1, with rsp_* held stable until rsp_ready. On the handshake, go to IDLE; cmd_ready is 1 in the next cycle.
//  Commands never overlap: cmd_ready=0 outside IDLE.
//  Latency (accept edge -> rsp_valid): read hit 3 cycles; read miss 5 + memory wait cycles.
//  Counters saturate at 2^CNT_W-1 and never wrap.
// TESTING
//  1. After reset, read 0x40; mem_ack 3 cycles after mem_req with mem_rdata=0xDEADBEEF -> FILL write 0xDEADBEEF@0x40; rsp rdata=0xDEADBEEF, hit=0; miss_count=1.
//  2. Repeat read 0x40 -> rsp_valid 3 cycles after accept, rdata=0xDEADBEEF, hit=1, mem_req never asserted; hit_count=1.
//  3. Write 0x80 data 0x00001234 -> cache_read_write high exactly 1 cycle, mem write addr 0x80 data 0x1234; rsp hit=0. Then read 0x80 -> hit=1, rdata=0x1234.
//  4. MEM_TIMEOUT=8, read miss with no mem_ack -> mem_req drops after 8 cycles; rsp_err=1, rdata=0, no FILL write.
//  5. Hold rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0; cmd_ready=1 in the cycle after the handshake.
//  6. Assert reset during MEM_RD -> mem_req=0 and counters=0 immediately; the next command completes normally.

Source files
------------

// File: rtl/cache_access_master.sv
// Requester-side controller for a direct-mapped cache: accepts CPU commands, drives the cache
// port, services read misses and write-through from backing memory, and returns one response each.
module cache_access_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_hit,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] cache_address,
  output logic [DATA_W-1:0] cache_data_in,
  output logic              cache_read_write,
  input  logic [DATA_W-1:0] cache_data_out,
  input  logic              cache_hit,
  output logic              mem_req,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int               TMR_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CHECK,
    ST_MEM_RD,
    ST_FILL,
    ST_MEM_WR,
    ST_RESP
  } state_t;

  state_t            r_state, w_next_state;

  // Latched command
  logic              r_write,   w_write;
  logic [ADDR_W-1:0] r_addr,    w_addr;
  logic [DATA_W-1:0] r_wdata,   w_wdata;
  logic [TMR_W-1:0]  r_timer,   w_timer;

  // Output registers; the w_ versions are the values they take at the next edge
  logic              r_cmd_ready,        w_cmd_ready;
  logic              r_rsp_valid,        w_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata,        w_rsp_rdata;
  logic              r_rsp_hit,          w_rsp_hit;
  logic              r_rsp_err,          w_rsp_err;
  logic [ADDR_W-1:0] r_cache_address,    w_cache_address;
  logic [DATA_W-1:0] r_cache_data_in,    w_cache_data_in;
  logic              r_cache_read_write, w_cache_read_write;
  logic              r_mem_req,          w_mem_req;
  logic              r_mem_write,        w_mem_write;
  logic [ADDR_W-1:0] r_mem_addr,         w_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata,        w_mem_wdata;
  logic [CNT_W-1:0]  r_hit_count,        w_hit_count;
  logic [CNT_W-1:0]  r_miss_count,       w_miss_count;

  logic              w_timeout;

  assign w_timeout = (r_timer == TMR_LAST);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
  endfunction

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case infers a latch.
    w_next_state       = r_state;
    w_write            = r_write;
    w_addr             = r_addr;
    w_wdata            = r_wdata;
    w_timer            = r_timer;
    w_cmd_ready        = 1'b0;
    w_rsp_valid        = 1'b0;
    w_rsp_rdata        = r_rsp_rdata;
    w_rsp_hit          = r_rsp_hit;
    w_rsp_err          = r_rsp_err;
    w_cache_address    = r_cache_address;
    w_cache_data_in    = r_cache_data_in;
    w_cache_read_write = 1'b0;
    w_mem_req          = 1'b0;
    w_mem_write        = r_mem_write;
    w_mem_addr         = r_mem_addr;
    w_mem_wdata        = r_mem_wdata;
    w_hit_count        = r_hit_count;
    w_miss_count       = r_miss_count;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_next_state       = ST_ISSUE;
          w_write            = cmd_write;
          w_addr             = cmd_addr;
          w_wdata            = cmd_wdata;
          w_cache_address    = cmd_addr;
          w_cache_data_in    = cmd_wdata;
          w_cache_read_write = cmd_write;
        end else begin
          w_cmd_ready = 1'b1;
        end
      end

      ST_ISSUE: begin
        w_next_state = ST_CHECK;
      end

      // The cache has registered its answer for the issued address by now
      ST_CHECK: begin
        w_timer = '0;
        if (cache_hit) begin
          w_hit_count = sat_inc(r_hit_count);
        end else begin
          w_miss_count = sat_inc(r_miss_count);
        end
        if (r_write) begin
          w_next_state = ST_MEM_WR;
          w_rsp_hit    = cache_hit;
          w_mem_req    = 1'b1;
          w_mem_write  = 1'b1;
          w_mem_addr   = r_addr;
          w_mem_wdata  = r_wdata;
        end else if (cache_hit) begin
          w_next_state = ST_RESP;
          w_rsp_valid  = 1'b1;
          w_rsp_rdata  = cache_data_out;
          w_rsp_hit    = 1'b1;
          w_rsp_err    = 1'b0;
        end else begin
          w_next_state = ST_MEM_RD;
          w_mem_req    = 1'b1;
          w_mem_write  = 1'b0;
          w_mem_addr   = r_addr;
        end
      end

      ST_MEM_RD: begin
        if (mem_ack) begin
          w_next_state       = ST_FILL;
          w_rsp_rdata        = mem_rdata;
          w_cache_address    = r_addr;
          w_cache_data_in    = mem_rdata;
          w_cache_read_write = 1'b1;
        end else if (w_timeout) begin
          w_next_state = ST_RESP;
          w_rsp_valid  = 1'b1;
          w_rsp_rdata  = '0;
          w_rsp_hit    = 1'b0;
          w_rsp_err    = 1'b1;
        end else begin
          w_mem_req = 1'b1;
          w_timer   = r_timer + TMR_W'(1);
        end
      end

      ST_FILL: begin
        w_next_state = ST_RESP;
        w_rsp_valid  = 1'b1;
        w_rsp_hit    = 1'b0;
        w_rsp_err    = 1'b0;
      end

      ST_MEM_WR: begin
        if (mem_ack) begin
          w_next_state = ST_RESP;
          w_rsp_valid  = 1'b1;
          w_rsp_rdata  = '0;
          w_rsp_err    = 1'b0;
        end else if (w_timeout) begin
          w_next_state = ST_RESP;
          w_rsp_valid  = 1'b1;
          w_rsp_rdata  = '0;
          w_rsp_hit    = 1'b0;
          w_rsp_err    = 1'b1;
        end else begin
          w_mem_req = 1'b1;
          w_timer   = r_timer + TMR_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
          w_cmd_ready  = 1'b1;
        end else begin
          w_rsp_valid = 1'b1;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state            <= ST_IDLE;
      r_write            <= 1'b0;
      r_addr             <= '0;
      r_wdata            <= '0;
      r_timer            <= '0;
      r_cmd_ready        <= 1'b0;
      r_rsp_valid        <= 1'b0;
      r_rsp_rdata        <= '0;
      r_rsp_hit          <= 1'b0;
      r_rsp_err          <= 1'b0;
      r_cache_address    <= '0;
      r_cache_data_in    <= '0;
      r_cache_read_write <= 1'b0;
      r_mem_req          <= 1'b0;
      r_mem_write        <= 1'b0;
      r_mem_addr         <= '0;
      r_mem_wdata        <= '0;
      r_hit_count        <= '0;
      r_miss_count       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      r_state            <= w_next_state;
      r_write            <= w_write;
      r_addr             <= w_addr;
      r_wdata            <= w_wdata;
      r_timer            <= w_timer;
      r_cmd_ready        <= w_cmd_ready;
      r_rsp_valid        <= w_rsp_valid;
      r_rsp_rdata        <= w_rsp_rdata;
      r_rsp_hit          <= w_rsp_hit;
      r_rsp_err          <= w_rsp_err;
      r_cache_address    <= w_cache_address;
      r_cache_data_in    <= w_cache_data_in;
      r_cache_read_write <= w_cache_read_write;
      r_mem_req          <= w_mem_req;
      r_mem_write        <= w_mem_write;
      r_mem_addr         <= w_mem_addr;
      r_mem_wdata        <= w_mem_wdata;
      r_hit_count        <= w_hit_count;
      r_miss_count       <= w_miss_count;
    end
  end

  assign cmd_ready        = r_cmd_ready;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_rdata        = r_rsp_rdata;
  assign rsp_hit          = r_rsp_hit;
  assign rsp_err          = r_rsp_err;
  assign cache_address    = r_cache_address;
  assign cache_data_in    = r_cache_data_in;
  assign cache_read_write = r_cache_read_write;
  assign mem_req          = r_mem_req;
  assign mem_write        = r_mem_write;
  assign mem_addr         = r_mem_addr;
  assign mem_wdata        = r_mem_wdata;
  assign hit_count        = r_hit_count;
  assign miss_count       = r_miss_count;

endmodule
